// File: rtl/mem_port_arbiter.sv
// Serializes the CPU's instruction and data request ports onto one shared
// physical-memory port, one transaction at a time, with round-robin on ties.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  imem_read,
  input  logic [ADDR_WIDTH-1:0] imem_address,
  output logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  imem_resp,

  input  logic                  dmem_read,
  input  logic                  dmem_write,
  input  logic [ADDR_WIDTH-1:0] dmem_address,
  input  logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic [1:0]            dmem_byte_enable,
  output logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  dmem_resp,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [DATA_WIDTH-1:0] pmem_wdata,
  output logic [1:0]            pmem_byte_enable,
  input  logic [DATA_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [1:0]            rst_sync;
  logic                  run_ok;
  logic                  last_grant_d;
  logic                  req_i, req_d;
  logic                  grant_i, grant_d;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [1:0]            lat_be;
  logic                  lat_write;

  // Reset asserts asynchronously; grants stay blocked until its release
  // has been seen on two clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run_ok = rst_sync[1];

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    req_i     = imem_read & run_ok;
    req_d     = (dmem_read | dmem_write) & run_ok;
    case (state)
      IDLE: begin
        // On a tie the port that was not served last wins.
        if (req_d && (!req_i || !last_grant_d)) begin
          grant_d   = 1'b1;
          state_nxt = SERVE_D;
        end else if (req_i) begin
          grant_i   = 1'b1;
          state_nxt = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    if (state == SERVE_I) begin
      pmem_read = 1'b1;
    end else if (state == SERVE_D) begin
      pmem_read  = ~lat_write;
      pmem_write = lat_write;
    end
  end

  assign pmem_address     = lat_addr;
  assign pmem_wdata       = lat_wdata;
  assign pmem_byte_enable = lat_be;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_be       <= 2'b00;
      lat_write    <= 1'b0;
      imem_resp    <= 1'b0;
      dmem_resp    <= 1'b0;
      imem_rdata   <= '0;
      dmem_rdata   <= '0;
    end else begin
      state     <= state_nxt;
      imem_resp <= 1'b0;
      dmem_resp <= 1'b0;

      // Request latch: the shared port is driven only from here.
      if (grant_d) begin
        lat_addr  <= dmem_address;
        lat_wdata <= dmem_wdata;
        lat_be    <= dmem_write ? dmem_byte_enable : 2'b11;
        lat_write <= dmem_write;
      end else if (grant_i) begin
        lat_addr  <= imem_address;
        lat_be    <= 2'b11;
        lat_write <= 1'b0;
      end

      if (state == SERVE_I && pmem_resp) begin
        imem_rdata   <= pmem_rdata;
        imem_resp    <= 1'b1;
        last_grant_d <= 1'b0;
      end

      if (state == SERVE_D && pmem_resp) begin
        if (!lat_write) begin
          dmem_rdata <= pmem_rdata;
        end
        dmem_resp    <= 1'b1;
        last_grant_d <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by randomized traffic checked against a
// transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_read;
  logic [AW-1:0] imem_address;
  logic [DW-1:0] imem_rdata;
  logic          imem_resp;
  logic          dmem_read;
  logic          dmem_write;
  logic [AW-1:0] dmem_address;
  logic [DW-1:0] dmem_wdata;
  logic [1:0]    dmem_byte_enable;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [DW-1:0] pmem_wdata;
  logic [1:0]    pmem_byte_enable;
  logic [DW-1:0] pmem_rdata;
  logic          pmem_resp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_byte_enable(pmem_byte_enable), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_read = 0; imem_address = '0;
    dmem_read = 0; dmem_write = 0; dmem_address = '0;
    dmem_wdata = '0; dmem_byte_enable = 2'b00;
    pmem_rdata = '0; pmem_resp = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    #2 rst_n = 0;
    repeat (2) tick();
    #2 rst_n = 1;
    repeat (3) tick();
  endtask

  // Transaction-level model state for the random phase
  int          mode;         // 0 free, 1 access, 2 respond, 3 cooldown
  int          ist, dst, ist0, dst0;
  int          lat;
  logic        e_port;       // 0 imem, 1 dmem
  logic        last_served;
  logic        e_wr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd, ret, e_ir, e_dr;
  logic [1:0]  e_be;
  logic        served;

  task automatic check_access(input string tag);
    chk({tag, "_rd"}, pmem_read, !e_wr);
    chk({tag, "_wr"}, pmem_write, e_wr);
    chk({tag, "_addr"}, pmem_address, e_addr);
    chk({tag, "_be"}, pmem_byte_enable, e_be);
    if (e_wr) chk({tag, "_wdata"}, pmem_wdata, e_wd);
  endtask

  initial begin
    clear_inputs();
    #2 rst_n = 0;
    tick();
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_pmem_addr", pmem_address, 0);
    chk("rst_pmem_wdata", pmem_wdata, 0);
    chk("rst_pmem_be", pmem_byte_enable, 0);
    chk("rst_imem_resp", imem_resp, 0);
    chk("rst_dmem_resp", dmem_resp, 0);
    chk("rst_imem_rdata", imem_rdata, 0);
    chk("rst_dmem_rdata", dmem_rdata, 0);
    #2 rst_n = 1;
    repeat (3) tick();

    // Single imem read, pmem answers three cycles after the strobe
    imem_read = 1; imem_address = 16'h0040;
    tick();
    chk("i1_strobe", pmem_read, 1);
    chk("i1_nowrite", pmem_write, 0);
    chk("i1_addr", pmem_address, 16'h0040);
    chk("i1_be", pmem_byte_enable, 2'b11);
    repeat (3) begin
      tick();
      chk("i1_strobe_held", pmem_read, 1);
    end
    pmem_resp = 1; pmem_rdata = 16'h1234;
    tick();
    pmem_resp = 0; pmem_rdata = 16'hDEAD;
    chk("i1_resp", imem_resp, 1);
    chk("i1_rdata", imem_rdata, 16'h1234);
    chk("i1_dresp", dmem_resp, 0);
    chk("i1_strobe_done", pmem_read, 0);
    tick();
    imem_read = 0;
    chk("i1_resp_pulse", imem_resp, 0);
    chk("i1_rdata_hold", imem_rdata, 16'h1234);
    repeat (3) begin
      tick();
      chk("i1_no_dup", pmem_read, 0);
    end

    // dmem write with partial byte mask and single-cycle pmem latency
    dmem_write = 1; dmem_address = 16'h0102; dmem_wdata = 16'hBEEF; dmem_byte_enable = 2'b10;
    tick();
    chk("w_strobe", pmem_write, 1);
    chk("w_noread", pmem_read, 0);
    chk("w_addr", pmem_address, 16'h0102);
    chk("w_wdata", pmem_wdata, 16'hBEEF);
    chk("w_be", pmem_byte_enable, 2'b10);
    pmem_resp = 1; pmem_rdata = 16'h7777;
    tick();
    pmem_resp = 0;
    dmem_write = 0;
    chk("w_resp", dmem_resp, 1);
    chk("w_rdata_unchanged", dmem_rdata, 0);
    chk("w_iresp", imem_resp, 0);
    chk("w_strobe_done", pmem_write, 0);
    tick();
    chk("w_resp_pulse", dmem_resp, 0);

    // Requester moves its address while the access is in flight
    dmem_read = 1; dmem_address = 16'h0200;
    tick();
    chk("a_addr", pmem_address, 16'h0200);
    dmem_address = 16'h0300;
    repeat (2) begin
      tick();
      chk("a_addr_stable", pmem_address, 16'h0200);
      chk("a_strobe", pmem_read, 1);
    end
    pmem_resp = 1; pmem_rdata = 16'h5A5A;
    tick();
    pmem_resp = 0; dmem_read = 0;
    chk("a_resp", dmem_resp, 1);
    chk("a_rdata", dmem_rdata, 16'h5A5A);
    tick();

    // Ties from reset alternate D, I, D, I
    do_reset();
    imem_read = 1; imem_address = 16'h0A00;
    dmem_read = 1; dmem_address = 16'h0D00;
    for (int k = 0; k < 4; k++) begin
      served = (k % 2 == 0);
      tick();
      chk("tie_addr", pmem_address, served ? 16'h0D00 : 16'h0A00);
      chk("tie_strobe", pmem_read, 1);
      pmem_resp = 1; pmem_rdata = 16'(k + 16'h100);
      tick();
      pmem_resp = 0;
      chk("tie_iresp", imem_resp, !served);
      chk("tie_dresp", dmem_resp, served);
      if (served) dmem_read = 0; else imem_read = 0;
      tick();
      if (served) dmem_read = 1; else imem_read = 1;
    end
    tick();
    imem_read = 0; dmem_read = 0;
    pmem_resp = 1;
    tick();
    pmem_resp = 0;
    repeat (2) tick();

    // Reset in the middle of an imem access
    imem_read = 1; imem_address = 16'h0ABC;
    tick();
    chk("r_strobe", pmem_read, 1);
    #2 rst_n = 0;
    #1;
    chk("r_strobe_drop", pmem_read, 0);
    chk("r_no_resp", imem_resp, 0);
    imem_read = 0;
    tick();
    #2 rst_n = 1;
    tick();
    pmem_resp = 1; pmem_rdata = 16'hFFFF;
    tick();
    pmem_resp = 0;
    chk("r_late_ignored", imem_resp, 0);
    chk("r_rdata", imem_rdata, 0);
    repeat (2) tick();
    chk("r_idle_rd", pmem_read, 0);
    chk("r_idle_resp", imem_resp, 0);
    imem_read = 1; imem_address = 16'h0123;
    tick();
    chk("r_after_strobe", pmem_read, 1);
    chk("r_after_addr", pmem_address, 16'h0123);
    pmem_resp = 1; pmem_rdata = 16'h4321;
    tick();
    pmem_resp = 0; imem_read = 0;
    chk("r_after_resp", imem_resp, 1);
    chk("r_after_rdata", imem_rdata, 16'h4321);

    // Randomized traffic against the transaction model
    do_reset();
    mode = 0; ist = 0; dst = 0; lat = 0;
    last_served = 0; e_ir = '0; e_dr = '0;
    e_port = 0; e_wr = 0; e_addr = '0; e_wd = '0; e_be = 2'b11; ret = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      ist0 = ist; dst0 = dst;
      chk("excl", pmem_read & pmem_write, 0);
      case (mode)
        0: begin
          if (imem_read || dmem_read || dmem_write) begin
            e_port = (dmem_read || dmem_write) && (!imem_read || last_served == 0);
            if (e_port) begin
              e_addr = dmem_address; e_wr = dmem_write; e_wd = dmem_wdata;
              e_be = dmem_write ? dmem_byte_enable : 2'b11;
            end else begin
              e_addr = imem_address; e_wr = 0; e_be = 2'b11;
            end
            last_served = e_port;
            lat = $urandom_range(0, 3);
            mode = 1;
            check_access("grant");
          end else begin
            chk("free_rd", pmem_read, 0);
            chk("free_wr", pmem_write, 0);
          end
          chk("free_iresp", imem_resp, 0);
          chk("free_dresp", dmem_resp, 0);
        end
        1: begin
          check_access("hold");
          chk("hold_iresp", imem_resp, 0);
          chk("hold_dresp", dmem_resp, 0);
        end
        2: begin
          if (!e_port) e_ir = ret;
          else if (!e_wr) e_dr = ret;
          chk("resp_i", imem_resp, !e_port);
          chk("resp_d", dmem_resp, e_port);
          chk("resp_rd", pmem_read, 0);
          chk("resp_wr", pmem_write, 0);
          if ($urandom_range(0, 1) == 0) begin
            if (e_port) begin dst = 0; dmem_read = 0; dmem_write = 0; end
            else begin ist = 0; imem_read = 0; end
          end else begin
            if (e_port) dst = 2; else ist = 2;
          end
          mode = 3;
        end
        default: begin
          chk("cool_rd", pmem_read, 0);
          chk("cool_wr", pmem_write, 0);
          chk("cool_iresp", imem_resp, 0);
          chk("cool_dresp", dmem_resp, 0);
          if (ist == 2) begin ist = 0; imem_read = 0; end
          if (dst == 2) begin dst = 0; dmem_read = 0; dmem_write = 0; end
          mode = 0;
        end
      endcase
      chk("irdata", imem_rdata, e_ir);
      chk("drdata", dmem_rdata, e_dr);

      if (mode == 1) begin
        pmem_rdata = 16'($urandom);
        if (lat == 0) begin
          pmem_resp = 1; ret = pmem_rdata; mode = 2;
        end else begin
          lat--; pmem_resp = 0;
        end
        if ($urandom_range(0, 1) == 0) begin
          if (e_port) begin dmem_address = 16'($urandom); dmem_wdata = 16'($urandom); end
          else imem_address = 16'($urandom);
        end
      end else begin
        pmem_resp = ($urandom_range(0, 4) == 0);
        pmem_rdata = 16'($urandom);
      end

      if (ist0 == 0 && ist == 0 && $urandom_range(0, 2) == 0) begin
        ist = 1; imem_read = 1; imem_address = 16'($urandom);
      end
      if (dst0 == 0 && dst == 0 && $urandom_range(0, 2) == 0) begin
        dst = 1;
        case ($urandom_range(0, 2))
          0: begin dmem_read = 1; dmem_write = 0; end
          1: begin dmem_read = 0; dmem_write = 1; end
          default: begin dmem_read = 1; dmem_write = 1; end
        endcase
        dmem_address = 16'($urandom);
        dmem_wdata = 16'($urandom);
        dmem_byte_enable = 2'($urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
